arq_tx_scheduler: RTL
=====================

# arq_tx_scheduler

Stop-and-wait ARQ scheduler on the sender line side, downstream of the mapper's line FIFO and transmit-record buffer. It moves each complete frame from the line FIFO to the serial transmitter and copies it into the record buffer. It then waits for an ACK/NAK from the return channel and replays the recorded frame on NAK or timeout. While a frame is outstanding it stalls the mapper through `o_line_retrans_req`.

## Interface
- `FRAME_BYTES`, 4096: bytes per frame (4 rows × 1024 cols), ≥ 2.
- `TIMEOUT_CYCLES`, 50000: ACK wait limit in clocks, ≥ 2.
- `MAX_RETRIES`, 3: replays allowed per frame before it is dropped.
- `i_clk` in 1: single clock.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_arq_en` in 1: ARQ mode; sampled only in IDLE.
- `i_line_frame_avail` in 1: line FIFO holds at least one complete frame.
- `i_line_valid` in 1: line FIFO head byte valid.
- `o_line_rd_en` out 1: pop line FIFO.
- `i_tx_ready` in 1: serial transmitter accepts a byte this cycle.
- `o_tx_valid` out 1: byte offered to the transmitter.
- `o_tx_sof` out 1: offered byte is frame byte 0.
- `o_sel_replay` out 1: transmitter mux selects record-buffer data (1) or line FIFO data (0).
- `o_rec_wr_en` out 1: write the current line byte into the record buffer at `o_rec_addr`.
- `o_rec_addr` out $clog2(FRAME_BYTES): record buffer byte address (write and replay read).
- `i_ack_valid` in 1: return-channel status strobe.
- `i_ack` in 1: 1 = ACK, 0 = NAK; qualified by `i_ack_valid`.
- `o_line_retrans_req` out 1: stall request to the mapper.
- `o_retry_cnt` out 2: replays performed for the current frame.
- `o_frame_fail` out 1: one-cycle pulse when a frame is dropped after `MAX_RETRIES`.
- `o_busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, SEND_NEW, WAIT_ACK, REPLAY.
- IDLE:
  - Latch `i_arq_en` into `arq_mode`.
  - Go to SEND_NEW when `i_line_frame_avail`.
  - On entry: byte counter = 0, retry_cnt = 0.
- SEND_NEW:
  - `o_tx_valid = i_line_valid`; `o_sel_replay = 0`.
  - Transfer when `i_line_valid && i_tx_ready`. On a transfer, `o_line_rd_en = 1`, and `o_rec_wr_en = arq_mode`.
  - `o_rec_addr` = byte counter, which increments per transfer.
  - After transfer of byte `FRAME_BYTES-1`: counter = 0. Go to WAIT_ACK if `arq_mode`, else IDLE.
- WAIT_ACK:
  - Timer counts from 0 starting on the entry cycle.
  - `i_ack_valid && i_ack` → IDLE.
  - `i_ack_valid && !i_ack`, or timer == `TIMEOUT_CYCLES-1` → retry decision.
  - ACK in the same cycle as the timeout wins.
- Retry decision:
  - retry_cnt < `MAX_RETRIES` → REPLAY, retry_cnt+1, counter = 0.
  - Otherwise pulse `o_frame_fail` and go to IDLE (frame discarded).
- REPLAY:
  - `o_tx_valid = 1`, `o_sel_replay = 1`, `o_rec_addr` = counter.
  - Counter advances on `i_tx_ready`.
  - After the last byte → WAIT_ACK, timer cleared.
  - No line FIFO pops and no record writes in this state.
- `o_tx_sof = o_tx_valid && counter == 0` in SEND_NEW/REPLAY.
- `o_line_retrans_req = 1` in WAIT_ACK and REPLAY, and in SEND_NEW when `arq_mode`. Otherwise 0.
- `i_ack_valid` outside WAIT_ACK is ignored, including during REPLAY.
- Reset mid-frame: all state is lost and the partially sent frame is abandoned. Line FIFO flush is the owner's responsibility.

## Timing
- Reset values: state IDLE; all outputs 0; counter, timer, retry_cnt 0; `arq_mode` 0.
- `o_line_rd_en`, `o_rec_wr_en`, `o_tx_valid`, `o_sel_replay`, `o_rec_addr`, `o_tx_sof` are combinational from state, counter and inputs. This gives same-cycle AXIS-style handshake and zero added latency.
- `o_line_retrans_req`, `o_busy`, `o_retry_cnt` are decoded from registered state only. `o_frame_fail` is registered (one cycle after the decision).
- Record buffer read latency is 1 cycle; the transmitter-side mux register absorbs it.
- State transitions take effect on the clock edge after the qualifying transfer or event.
- Counter wraps only via explicit clear at `FRAME_BYTES-1`. Timer saturates at `TIMEOUT_CYCLES-1` (never wraps).

## Structure
- Shared package holds:
  - state encoding (2-bit localparams),
  - `FRAME_BYTES` and `TIMEOUT_CYCLES` defaults,
  - ACK/NAK encoding.
- One sub-module, `arq_timer`: load/clear, enable, terminal-count flag, parameterised by `TIMEOUT_CYCLES`.

## Test plan
Bench uses `FRAME_BYTES=16`, `TIMEOUT_CYCLES=20`, `MAX_RETRIES=3`.
- Non-ARQ streaming, `i_tx_ready` always 1:
  - Two frames produce 32 `o_line_rd_en` pulses, `o_tx_sof` at bytes 0 and 16, zero `o_rec_wr_en`.
  - `o_line_retrans_req` never asserts.
- ARQ, ACK 5 cycles after the last byte:
  - 16 record writes at addresses 0..15, then WAIT_ACK with `o_line_retrans_req` high.
  - Return to IDLE; `o_retry_cnt` = 0.
- ARQ, NAK:
  - REPLAY emits 16 bytes with `o_sel_replay=1`, addresses 0..15, and no line pops.
  - `o_retry_cnt` = 1; a subsequent ACK → IDLE.
- ARQ, no ACK:
  - Timeouts at 20 cycles each produce 3 replays.
  - The 4th timeout gives a single `o_frame_fail` pulse and IDLE.
- ARQ, `i_tx_ready` toggling 1010… during SEND_NEW and REPLAY:
  - Exactly 16 transfers each, addresses never skip.
  - ACK and timeout in the same cycle → IDLE, no replay.
- `i_rst` asserted mid-REPLAY at byte 7:
  - All outputs 0 asynchronously; state IDLE.
  - A new frame then starts at address 0 with `o_retry_cnt` 0.

Source files
------------

// File: rtl/arq_tx_scheduler_pkg.sv
// Shared definitions for the stop-and-wait ARQ transmit scheduler.
package arq_tx_scheduler_pkg;

    localparam int unsigned FRAME_BYTES_DEF    = 4096;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 50000;
    localparam int unsigned MAX_RETRIES_DEF    = 3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SEND_NEW = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_REPLAY   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_SEND_NEW = ST_SEND_NEW,
        S_WAIT_ACK = ST_WAIT_ACK,
        S_REPLAY   = ST_REPLAY
    } arq_state_e;

    localparam logic ACK_OK  = 1'b1;
    localparam logic ACK_NAK = 1'b0;

endpackage

// File: rtl/arq_timer.sv
// ACK wait timer: counts while enabled, saturates at the terminal count.
module arq_timer
    import arq_tx_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned   TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !tc_c) begin
            count <= count + TW'(1);
        end
    end

    assign tc_c = (count == TERM);

endmodule

// File: rtl/arq_tx_scheduler.sv
// Stop-and-wait ARQ scheduler: streams line frames to the transmitter,
// records them, and replays on NAK or ACK timeout.
module arq_tx_scheduler
    import arq_tx_scheduler_pkg::*;
#(
    parameter int unsigned FRAME_BYTES    = FRAME_BYTES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES    = MAX_RETRIES_DEF
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_arq_en,
    input  logic                           i_line_frame_avail,
    input  logic                           i_line_valid,
    output logic                           o_line_rd_en,
    input  logic                           i_tx_ready,
    output logic                           o_tx_valid,
    output logic                           o_tx_sof,
    output logic                           o_sel_replay,
    output logic                           o_rec_wr_en,
    output logic [$clog2(FRAME_BYTES)-1:0] o_rec_addr,
    input  logic                           i_ack_valid,
    input  logic                           i_ack,
    output logic                           o_line_retrans_req,
    output logic [1:0]                     o_retry_cnt,
    output logic                           o_frame_fail,
    output logic                           o_busy
);

    localparam int unsigned   AW        = $clog2(FRAME_BYTES);
    localparam logic [AW-1:0] LAST_BYTE = AW'(FRAME_BYTES - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

    arq_state_e    state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [1:0]    retry_cnt, retry_n;
    logic          arq_mode, arq_mode_n;
    logic          fail_n;
    logic          timer_clr, timer_en, timeout_c;

    arq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .clear (timer_clr),
        .en    (timer_en),
        .tc_c  (timeout_c)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            retry_cnt    <= '0;
            arq_mode     <= 1'b0;
            o_frame_fail <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            retry_cnt    <= retry_n;
            arq_mode     <= arq_mode_n;
            o_frame_fail <= fail_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        retry_n      = retry_cnt;
        arq_mode_n   = arq_mode;
        fail_n       = 1'b0;
        timer_clr    = 1'b1;
        timer_en     = 1'b0;
        o_line_rd_en = 1'b0;
        o_tx_valid   = 1'b0;
        o_tx_sof     = 1'b0;
        o_sel_replay = 1'b0;
        o_rec_wr_en  = 1'b0;
        o_rec_addr   = '0;

        case (state)
            S_IDLE: begin
                arq_mode_n = i_arq_en;
                cnt_n      = '0;
                retry_n    = '0;
                if (i_line_frame_avail) begin
                    state_n = S_SEND_NEW;
                end
            end

            S_SEND_NEW: begin
                o_tx_valid = i_line_valid;
                o_tx_sof   = i_line_valid && (cnt == '0);
                o_rec_addr = cnt;
                if (i_line_valid && i_tx_ready) begin
                    o_line_rd_en = 1'b1;
                    o_rec_wr_en  = arq_mode;
                    if (cnt == LAST_BYTE) begin
                        cnt_n   = '0;
                        state_n = arq_mode ? S_WAIT_ACK : S_IDLE;
                    end else begin
                        cnt_n = cnt + AW'(1);
                    end
                end
            end

            S_WAIT_ACK: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                // ACK is tested first so it wins over a coincident timeout
                if (i_ack_valid && (i_ack == ACK_OK)) begin
                    state_n = S_IDLE;
                    retry_n = '0;
                    cnt_n   = '0;
                end else if ((i_ack_valid && (i_ack == ACK_NAK)) || timeout_c) begin
                    cnt_n = '0;
                    if (retry_cnt < RETRY_MAX) begin
                        state_n = S_REPLAY;
                        retry_n = retry_cnt + 2'd1;
                    end else begin
                        state_n = S_IDLE;
                        retry_n = '0;
                        fail_n  = 1'b1;
                    end
                end
            end

            S_REPLAY: begin
                o_tx_valid   = 1'b1;
                o_tx_sof     = (cnt == '0);
                o_sel_replay = 1'b1;
                o_rec_addr   = cnt;
                if (i_tx_ready) begin
                    if (cnt == LAST_BYTE) begin
                        cnt_n   = '0;
                        state_n = S_WAIT_ACK;
                    end else begin
                        cnt_n = cnt + AW'(1);
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign o_retry_cnt        = retry_cnt;
    assign o_busy             = (state != S_IDLE);
    assign o_line_retrans_req = (state == S_WAIT_ACK) || (state == S_REPLAY) ||
                                ((state == S_SEND_NEW) && arq_mode);

endmodule
